// File: rtl/nn_pkg.sv
// Shared Q8.8 neural-datapath definitions: word format, saturation
// limits, the constant one, and the MAC accumulator state encoding.
package nn_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int FRACT_WIDTH = 8;

    localparam logic [DATA_WIDTH-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = 16'h8000;
    localparam logic [DATA_WIDTH-1:0] ONE_Q88 = 16'h0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } mac_state_e;

endpackage

// File: rtl/q_round_sat.sv
// Combinational round-half-up and saturate from a wide fixed-point
// accumulator (FRACT_WIDTH extra fractional bits) down to a data word.
// Ports: acc_in (wide signed), q_out (rounded/clipped word),
//        sat_out (1 when q_out was clipped).
module q_round_sat #(
    parameter int ACC_WIDTH   = 40,
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    output logic signed [DATA_WIDTH-1:0] q_out,
    output logic                         sat_out
);

    localparam logic signed [ACC_WIDTH-1:0] HALF =
        ACC_WIDTH'(1) <<< (FRACT_WIDTH - 1);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}},
         {(DATA_WIDTH-1){1'b1}}};

    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}},
         {(DATA_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] biased;
    logic signed [ACC_WIDTH-1:0] rounded;

    // Adding half an LSB before an arithmetic shift rounds half toward +inf.
    assign biased  = acc_in + HALF;
    assign rounded = biased >>> FRACT_WIDTH;

    always_comb begin
        q_out   = rounded[DATA_WIDTH-1:0];
        sat_out = 1'b0;
        if (rounded > MAX_V) begin
            q_out   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            sat_out = 1'b1;
        end else if (rounded < MIN_V) begin
            q_out   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            sat_out = 1'b1;
        end
    end

endmodule

// File: rtl/neuron_mac_accumulator.sv
// Streaming Q8.8 dot product + bias ahead of the tanh stage.
// Ports: clk, reset (async, active low); x_in/w_in/bias_in with
//        in_valid/in_ready; out_data/out_sat with out_valid/out_ready.
module neuron_mac_accumulator #(
    parameter int DATA_WIDTH  = nn_pkg::DATA_WIDTH,
    parameter int FRACT_WIDTH = nn_pkg::FRACT_WIDTH,
    parameter int N_TAPS      = 8,
    parameter int ACC_WIDTH   = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic signed [DATA_WIDTH-1:0] w_in,
    input  logic signed [DATA_WIDTH-1:0] bias_in,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_sat
);

    import nn_pkg::*;

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TAPS - 1);

    mac_state_e state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_sat_q, out_sat_d;
    logic                         live_q, live_d;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    prod_ext;
    logic signed [ACC_WIDTH-1:0]    bias_ext;
    logic signed [DATA_WIDTH-1:0]   rs_data;
    logic                           rs_sat;
    logic                           beat;

    assign prod     = x_in * w_in;
    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    // Bias is Q8.8; shifting aligns it with the Q16.16 products.
    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH-FRACT_WIDTH){bias_in[DATA_WIDTH-1]}},
                       bias_in, {FRACT_WIDTH{1'b0}}};

    // live_q keeps in_ready low until the first edge after reset release.
    assign in_ready = live_q &&
                      (state_q == ST_IDLE || state_q == ST_ACC);
    assign beat     = in_valid && in_ready;

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sat   = out_sat_q;

    q_round_sat #(
        .ACC_WIDTH   (ACC_WIDTH),
        .DATA_WIDTH  (DATA_WIDTH),
        .FRACT_WIDTH (FRACT_WIDTH)
    ) u_round (
        .acc_in  (acc_q),
        .q_out   (rs_data),
        .sat_out (rs_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sat_d   = out_sat_q;
        live_d      = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (beat) begin
                    acc_d   = prod_ext + bias_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = (N_TAPS == 1) ? ST_FINAL : ST_ACC;
                end
            end
            ST_ACC: begin
                if (beat) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                out_data_d  = rs_data;
                out_sat_d   = rs_sat;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_sat_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sat_q   <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sat_q   <= out_sat_d;
            live_q      <= live_d;
        end
    end

endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// Bench for neuron_mac_accumulator with N_TAPS=4: directed beats,
// integer reference model of the dot product, per-cycle output check.
module tb_neuron_mac_accumulator;

    import nn_pkg::*;

    localparam int NT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] x_in = '0;
    logic [15:0] w_in = '0;
    logic [15:0] bias_in = '0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_sat;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_mac_accumulator #(
        .N_TAPS (NT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x_in      (x_in),
        .w_in      (w_in),
        .bias_in   (bias_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat)
    );

    typedef struct {
        logic [15:0] d;
        logic        s;
    } req_t;

    req_t   req_q[$];
    longint acc_m = 0;
    int     nbeat = 0;
    int     cyc = 0;
    int     last_beat = -100;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Real-valued result is sum/65536; round half up to 1/256 and clip.
    function automatic req_t model(input longint sum);
        longint r;
        req_t   e;
        r = (sum + 128) / 256;
        if ((sum + 128) < 0 && ((sum + 128) % 256) != 0) r = r - 1;
        if (r > 32767) begin
            e.d = SAT_MAX;
            e.s = 1'b1;
        end else if (r < -32768) begin
            e.d = SAT_MIN;
            e.s = 1'b1;
        end else begin
            e.d = 16'(r);
            e.s = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) begin : monitor
        longint p;
        if (!reset) begin
            nbeat = 0;
            req_q.delete();
        end else if (in_valid && in_ready) begin
            p = longint'($signed(x_in)) * longint'($signed(w_in));
            if (nbeat == 0)
                acc_m = p + longint'($signed(bias_in)) * 256;
            else
                acc_m = acc_m + p;
            nbeat++;
            last_beat = cyc;
            if (nbeat == NT) begin
                req_q.push_back(model(acc_m));
                nbeat = 0;
            end
        end
        cyc++;
    end

    logic prev_v = 1'b0;
    logic prev_r = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            if (prev_v && !prev_r) check("valid_hold", out_valid, 1);
            if (out_valid) begin
                check("rdy_low_out", in_ready, 0);
                if (!prev_v) check("latency", cyc, last_beat + 2);
                if (req_q.size() == 0) begin
                    check("unexpected_out", req_q.size(), 1);
                end else begin
                    check("model_data", out_data, req_q[0].d);
                    check("model_sat", out_sat, req_q[0].s);
                    if (out_ready) void'(req_q.pop_front());
                end
            end
            prev_v = out_valid;
            prev_r = out_ready;
        end
    end

    task automatic send(input logic [15:0] x,
                        input logic [15:0] w,
                        input logic [15:0] b);
        int n = 0;
        x_in = x;
        w_in = w;
        bias_in = b;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) check("send_timeout", n, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run4(input logic [15:0] x,
                        input logic [15:0] w,
                        input logic [15:0] b);
        for (int i = 0; i < NT; i++) send(x, w, b);
    endtask

    task automatic wait_valid();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 100);
    endtask

    task automatic expect_out(input string name,
                              input logic [15:0] d,
                              input logic s);
        wait_valid();
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"}, out_data, d);
        check({name, "_sat"}, out_sat, s);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_sat", out_sat, 0);
        check("rst_rdy", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("rdy_before_edge", in_ready, 0);
        @(negedge clk);
        check("rdy_after_edge", in_ready, 1);
        @(posedge clk);
        #1;

        run4(ONE_Q88, 16'h0080, 16'h0040);
        expect_out("basic", 16'h0240, 1'b0);

        run4(16'h7F00, 16'h7F00, 16'h0000);
        expect_out("sat_pos", 16'h7FFF, 1'b1);
        run4(16'h7F00, 16'h8100, 16'h0000);
        expect_out("sat_neg", 16'h8000, 1'b1);

        run4(16'h0001, 16'h0080, 16'h0000);
        expect_out("round_2", 16'h0002, 1'b0);
        send(16'h0001, 16'h0040, 16'h0000);
        send(16'h0001, 16'h0040, 16'h0000);
        send(16'h0000, 16'h0000, 16'h0000);
        send(16'h0000, 16'h0000, 16'h0000);
        expect_out("half_up", 16'h0001, 1'b0);

        send(16'hFFFF, 16'h0080, 16'h0000);
        for (int i = 0; i < 3; i++) send(16'h0000, 16'h0000, 16'h0000);
        expect_out("neg_half", 16'h0000, 1'b0);

        run4(16'h0000, 16'h0000, 16'h7FFF);
        expect_out("edge_max", 16'h7FFF, 1'b0);
        run4(16'h0000, 16'h0000, 16'h8000);
        expect_out("edge_min", 16'h8000, 1'b0);
        send(16'h0001, 16'h0080, 16'h7FFF);
        for (int i = 0; i < 3; i++) send(16'h0000, 16'h0000, 16'h0000);
        expect_out("round_over", 16'h7FFF, 1'b1);

        send(ONE_Q88, ONE_Q88, ONE_Q88);
        for (int i = 0; i < 3; i++) send(ONE_Q88, ONE_Q88, 16'h7FFF);
        expect_out("bias_first", 16'h0500, 1'b0);

        for (int k = 0; k < NT; k++) begin
            send(ONE_Q88, ONE_Q88, 16'h0000);
            if (k < NT - 1) begin
                repeat (2) begin
                    @(negedge clk);
                    check("rdy_bubble", in_ready, 1);
                    @(posedge clk);
                    #1;
                end
            end
        end
        expect_out("bubbles", 16'h0400, 1'b0);

        out_ready = 1'b0;
        run4(16'h7F00, 16'h7F00, 16'h0000);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, 16'h7FFF);
            check("bp_sat", out_sat, 1);
            check("bp_rdy", in_ready, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rel_hold", out_valid, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rel_valid", out_valid, 0);
        check("rel_rdy", in_ready, 1);
        check("rel_sat", out_sat, 0);
        check("rel_data", out_data, 16'h7FFF);
        @(posedge clk);
        #1;

        send(ONE_Q88, ONE_Q88, ONE_Q88);
        send(ONE_Q88, ONE_Q88, ONE_Q88);
        reset = 1'b0;
        #1;
        check("abort_data", out_data, 0);
        check("abort_valid", out_valid, 0);
        check("abort_sat", out_sat, 0);
        check("abort_rdy", in_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        run4(ONE_Q88, 16'h0080, 16'h0000);
        expect_out("fresh", 16'h0200, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", req_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
